// File: rtl/ascon_ctrl_fsm.sv
// Ascon-128 encryption control FSM: sequences init, AD, PT, finalization and tag capture.
// Optional abort input is enabled by defining ASCON_CTRL_ABORT_EN.
module ascon_ctrl_fsm #(
    parameter int N_AD = 1,
    parameter int N_PT = 3
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [3:0] round_i,
    input  logic       data_valid_i,
`ifdef ASCON_CTRL_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       data_ready_o,
    output logic       input_select_o,
    output logic       ena_cpt_o,
    output logic       init_a_o,
    output logic       init_b_o,
    output logic       ena_xor_up_o,
    output logic       ena_xor_down_o,
    output logic [2:0] xor_down_sel_o,
    output logic       ena_reg_state_o,
    output logic       ena_cipher_o,
    output logic       ena_tag_o,
    output logic       cipher_valid_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int AD_W = (N_AD > 1) ? $clog2(N_AD) : 1;
    localparam int PT_W = (N_PT > 1) ? $clog2(N_PT) : 1;
    localparam logic [AD_W-1:0] AD_LAST = AD_W'(N_AD - 1);
    localparam logic [PT_W-1:0] PT_LAST = PT_W'(N_PT - 1);
    localparam logic [3:0] LAST_ROUND = 4'd11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_AD_FIRST,
        S_AD_PERM,
        S_PT_FIRST,
        S_PT_PERM,
        S_FIN_FIRST,
        S_FIN_PERM,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AD_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [PT_W-1:0] pt_cnt_q, pt_cnt_d;
    logic            cipher_valid_q;
    logic            abort_w;

`ifdef ASCON_CTRL_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q        <= S_IDLE;
            ad_cnt_q       <= '0;
            pt_cnt_q       <= '0;
            cipher_valid_q <= 1'b0;
        end else if (abort_w && (state_q != S_IDLE)) begin
            state_q        <= S_IDLE;
            ad_cnt_q       <= '0;
            pt_cnt_q       <= '0;
            cipher_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ad_cnt_q       <= ad_cnt_d;
            pt_cnt_q       <= pt_cnt_d;
            cipher_valid_q <= ena_cipher_o;
        end
    end

    assign cipher_valid_o = cipher_valid_q;
    assign busy_o         = (state_q != S_IDLE);

    always_comb begin
        state_d         = state_q;
        ad_cnt_d        = ad_cnt_q;
        pt_cnt_d        = pt_cnt_q;
        data_ready_o    = 1'b0;
        input_select_o  = 1'b0;
        ena_cpt_o       = 1'b0;
        init_a_o        = 1'b0;
        init_b_o        = 1'b0;
        ena_xor_up_o    = 1'b0;
        ena_xor_down_o  = 1'b0;
        xor_down_sel_o  = 3'b000;
        ena_reg_state_o = 1'b0;
        ena_cipher_o    = 1'b0;
        ena_tag_o       = 1'b0;
        done_o          = 1'b0;

        case (state_q)
            S_IDLE: begin
                init_a_o = 1'b1;
                if (start_i) state_d = S_INIT;
            end
            S_INIT: begin
                ena_reg_state_o = 1'b1;
                ena_cpt_o       = 1'b1;
                input_select_o  = (round_i != 4'd0);
                if (round_i == LAST_ROUND) begin
                    ena_cpt_o      = 1'b0;
                    init_b_o       = 1'b1;
                    ena_xor_down_o = 1'b1;
                    xor_down_sel_o = 3'b001;
                    state_d        = S_AD_FIRST;
                end
            end
            S_AD_FIRST, S_PT_FIRST, S_FIN_FIRST: begin
                // Block entry holds every enable low until the source presents data.
                if (data_valid_i) begin
                    data_ready_o    = 1'b1;
                    ena_xor_up_o    = 1'b1;
                    ena_reg_state_o = 1'b1;
                    ena_cpt_o       = 1'b1;
                    input_select_o  = 1'b1;
                    ena_cipher_o    = (state_q != S_AD_FIRST);
                    case (state_q)
                        S_AD_FIRST: state_d = S_AD_PERM;
                        S_PT_FIRST: state_d = S_PT_PERM;
                        default:    state_d = S_FIN_PERM;
                    endcase
                end
            end
            S_AD_PERM: begin
                ena_reg_state_o = 1'b1;
                ena_cpt_o       = 1'b1;
                input_select_o  = 1'b1;
                if (round_i == LAST_ROUND) begin
                    ena_cpt_o = 1'b0;
                    if (ad_cnt_q != AD_LAST) begin
                        ad_cnt_d = ad_cnt_q + AD_W'(1);
                        init_b_o = 1'b1;
                        state_d  = S_AD_FIRST;
                    end else begin
                        // With a single PT block the final-block key XOR is folded in here.
                        ena_xor_down_o = 1'b1;
                        xor_down_sel_o = (N_PT == 1) ? 3'b110 : 3'b010;
                        ad_cnt_d       = '0;
                        if (N_PT > 1) begin
                            init_b_o = 1'b1;
                            state_d  = S_PT_FIRST;
                        end else begin
                            init_a_o = 1'b1;
                            state_d  = S_FIN_FIRST;
                        end
                    end
                end
            end
            S_PT_PERM: begin
                ena_reg_state_o = 1'b1;
                ena_cpt_o       = 1'b1;
                input_select_o  = 1'b1;
                if (round_i == LAST_ROUND) begin
                    ena_cpt_o = 1'b0;
                    pt_cnt_d  = pt_cnt_q + PT_W'(1);
                    if (pt_cnt_d == PT_LAST) begin
                        ena_xor_down_o = 1'b1;
                        xor_down_sel_o = 3'b100;
                        init_a_o       = 1'b1;
                        state_d        = S_FIN_FIRST;
                    end else begin
                        init_b_o = 1'b1;
                        state_d  = S_PT_FIRST;
                    end
                end
            end
            S_FIN_PERM: begin
                ena_reg_state_o = 1'b1;
                ena_cpt_o       = 1'b1;
                input_select_o  = 1'b1;
                if (round_i == LAST_ROUND) begin
                    ena_cpt_o      = 1'b0;
                    ena_xor_down_o = 1'b1;
                    xor_down_sel_o = 3'b001;
                    ena_tag_o      = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                done_o   = 1'b1;
                pt_cnt_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: three instances (N_AD,N_PT) = (1,3), (1,1), (2,2), each with a round-counter model.
// An event-schedule reference model predicts every output cycle by cycle from the valid pattern driven.
module tb_ascon_ctrl_fsm;

    localparam int NI   = 3;
    localparam int MAXK = 256;

    localparam int B_DONE = 0;
    localparam int B_BUSY = 1;
    localparam int B_CV   = 2;
    localparam int B_TAG  = 3;
    localparam int B_CIPH = 4;
    localparam int B_REG  = 5;
    localparam int B_SEL  = 6;
    localparam int B_XDN  = 9;
    localparam int B_XUP  = 10;
    localparam int B_IB   = 11;
    localparam int B_IA   = 12;
    localparam int B_CPT  = 13;
    localparam int B_ISEL = 14;
    localparam int B_RDY  = 15;
    localparam logic [15:0] IDLE_VEC = 16'h1000;

    function automatic int nad_of(input int i);
        case (i)
            0: return 1;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int npt_of(input int i);
        case (i)
            0: return 3;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    logic clk = 1'b0;
    logic resetb;
    logic [NI-1:0] start_a;
    logic [NI-1:0] valid_a;
`ifdef ASCON_CTRL_ABORT_EN
    logic [NI-1:0] abort_a;
`endif
    logic [NI-1:0][15:0] outv;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic [3:0] rnd_q;
        logic rdy, isel, cpt, ia, ib, xup, xdn, rs, ci, tg, cv, bz, dn;
        logic [2:0] sel;

        ascon_ctrl_fsm #(.N_AD(nad_of(gi)), .N_PT(npt_of(gi))) u_dut (
            .clock_i        (clk),
            .resetb_i       (resetb),
            .start_i        (start_a[gi]),
            .round_i        (rnd_q),
            .data_valid_i   (valid_a[gi]),
`ifdef ASCON_CTRL_ABORT_EN
            .abort_i        (abort_a[gi]),
`endif
            .data_ready_o   (rdy),
            .input_select_o (isel),
            .ena_cpt_o      (cpt),
            .init_a_o       (ia),
            .init_b_o       (ib),
            .ena_xor_up_o   (xup),
            .ena_xor_down_o (xdn),
            .xor_down_sel_o (sel),
            .ena_reg_state_o(rs),
            .ena_cipher_o   (ci),
            .ena_tag_o      (tg),
            .cipher_valid_o (cv),
            .busy_o         (bz),
            .done_o         (dn)
        );

        // Datapath round counter: preset 0, preset 6, or increment.
        always_ff @(posedge clk) begin
            if (!resetb)  rnd_q <= 4'd0;
            else if (ia)  rnd_q <= 4'd0;
            else if (ib)  rnd_q <= 4'd6;
            else if (cpt) rnd_q <= rnd_q + 4'd1;
        end

        assign outv[gi] = {rdy, isel, cpt, ia, ib, xup, xdn, sel, rs, ci, tg, cv, bz, dn};
    end

    int checks = 0;
    int errors = 0;

    bit          vpat    [MAXK];
    bit          spat    [MAXK];
    logic [15:0] exp_vec [MAXK];
    logic [15:0] obs     [MAXK];
    int          exp_done;
    int          m_done, m_xfers, m_cv, m_sel100, m_sel100_k;

    // Schedule model: block windows open 13 cycles after start and 6 cycles after each transfer;
    // the tag is ready 12 cycles after the final transfer.
    task automatic build_model(input int d);
        int nad, npt, nb, t, x, e;
        int xfer [8];
        bit stall [MAXK];
        logic [2:0] s;
        nad = nad_of(d);
        npt = npt_of(d);
        nb  = nad + npt;
        for (int k = 0; k < MAXK; k++) stall[k] = 1'b0;
        t = 13;
        exp_done = 0;
        for (int b = 0; b < nb; b++) begin
            x = t;
            while (!vpat[x] && x < MAXK - 40) x++;
            xfer[b] = x;
            for (int q = t; q < x; q++) stall[q] = 1'b1;
            if (b < nb - 1) t = x + 6;
            else exp_done = x + 12;
        end
        for (int k = 0; k < MAXK; k++) begin
            exp_vec[k] = 16'h0;
            if (k == 0 || k > exp_done) exp_vec[k][B_IA] = 1'b1;
            else if (k == exp_done) begin
                exp_vec[k][B_BUSY] = 1'b1;
                exp_vec[k][B_DONE] = 1'b1;
            end else begin
                exp_vec[k][B_BUSY] = 1'b1;
                if (!stall[k]) begin
                    exp_vec[k][B_REG]  = 1'b1;
                    exp_vec[k][B_CPT]  = 1'b1;
                    exp_vec[k][B_ISEL] = (k != 1);
                end
            end
        end
        exp_vec[12][B_CPT] = 1'b0;
        exp_vec[12][B_IB]  = 1'b1;
        exp_vec[12][B_XDN] = 1'b1;
        exp_vec[12][B_SEL +: 3] = 3'b001;
        for (int b = 0; b < nb; b++) begin
            x = xfer[b];
            exp_vec[x][B_RDY] = 1'b1;
            exp_vec[x][B_XUP] = 1'b1;
            if (b >= nad) begin
                exp_vec[x][B_CIPH]  = 1'b1;
                exp_vec[x+1][B_CV]  = 1'b1;
            end
            if (b < nb - 1) begin
                e = x + 5;
                exp_vec[e][B_CPT] = 1'b0;
                if (b == nb - 2) exp_vec[e][B_IA] = 1'b1;
                else exp_vec[e][B_IB] = 1'b1;
                s = 3'b000;
                if (b == nad - 1) s = (npt == 1) ? 3'b110 : 3'b010;
                if (b == nb - 2 && b >= nad) s = s | 3'b100;
                if (s != 3'b000) begin
                    exp_vec[e][B_XDN] = 1'b1;
                    exp_vec[e][B_SEL +: 3] = s;
                end
            end else begin
                e = x + 11;
                exp_vec[e][B_CPT] = 1'b0;
                exp_vec[e][B_XDN] = 1'b1;
                exp_vec[e][B_SEL +: 3] = 3'b001;
                exp_vec[e][B_TAG] = 1'b1;
            end
        end
    endtask

    // Drives one operation on instance d (start at relative cycle 0) and records outputs per cycle.
    task automatic run_op(input int d);
        build_model(d);
        for (int k = 0; k <= exp_done + 2; k++) begin
            start_a[d] = (k == 0) ? 1'b1 : (spat[k] && k <= exp_done);
            valid_a[d] = vpat[k];
            @(negedge clk);
            obs[k] = outv[d];
            @(posedge clk);
            #1;
        end
        start_a[d] = 1'b0;
        valid_a[d] = 1'b0;
        m_done = -1; m_xfers = 0; m_cv = 0; m_sel100 = 0; m_sel100_k = -1;
        for (int k = 0; k <= exp_done + 2; k++) begin
            if (obs[k][B_DONE] && m_done < 0) m_done = k;
            if (obs[k][B_RDY]) m_xfers++;
            if (obs[k][B_CV]) m_cv++;
            if (obs[k][B_XDN] && obs[k][B_SEL +: 3] == 3'b100) begin
                m_sel100++;
                m_sel100_k = k;
            end
        end
        $display("op inst=%0d N_AD=%0d N_PT=%0d done_k=%0d xfers=%0d cipher_pulses=%0d",
                 d, nad_of(d), npt_of(d), m_done, m_xfers, m_cv);
    endtask

    task automatic fill_pattern(input bit rnd_valid, input bit rnd_start);
        for (int k = 0; k < MAXK; k++) begin
            vpat[k] = (rnd_valid && k < 120) ? ($urandom_range(0, 9) < 7) : 1'b1;
            spat[k] = rnd_start ? ($urandom_range(0, 9) == 0) : 1'b0;
        end
    endtask

    task automatic test_reset();
        bit saw;
        @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            checks++;
            if (outv[d] !== IDLE_VEC) begin
                errors++;
                $display("FAIL reset_idle inst=%0d got %b expected %b", d, outv[d], IDLE_VEC);
            end
        end
        @(posedge clk); #1;
        start_a[0] = 1'b1;
        valid_a[0] = 1'b1;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (g_dut[0].rnd_q !== 4'd5 || outv[0][B_BUSY] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_init_reach got round=%0d busy=%b expected round=5 busy=1",
                     g_dut[0].rnd_q, outv[0][B_BUSY]);
        end
        resetb = 1'b0;
        @(posedge clk); #1;
        resetb = 1'b1;
        @(negedge clk);
        checks++;
        if (outv[0] !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_mid_init got %b expected %b", outv[0], IDLE_VEC);
        end
        saw = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (outv[0][B_DONE] || outv[0][B_BUSY]) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got activity=%b expected 0", saw);
        end
        valid_a[0] = 1'b0;
        @(posedge clk); #1;
        $display("op reset mid-INIT on inst=0 done");
    endtask

    task automatic test_single_pt();
        fill_pattern(1'b0, 1'b0);
        run_op(1);
        checks++;
        if (m_done !== 31) begin errors++; $display("FAIL n11_latency got %0d expected 31", m_done); end
        checks++;
        if (m_xfers !== 2) begin errors++; $display("FAIL n11_xfers got %0d expected 2", m_xfers); end
        checks++;
        if (obs[18][B_XDN] !== 1'b1 || obs[18][B_SEL +: 3] !== 3'b110) begin
            errors++;
            $display("FAIL n11_ad_sel got xdn=%b sel=%b expected xdn=1 sel=110", obs[18][B_XDN], obs[18][B_SEL +: 3]);
        end
        checks++;
        if (obs[30][B_SEL +: 3] !== 3'b001 || obs[30][B_TAG] !== 1'b1) begin
            errors++;
            $display("FAIL n11_fin_sel got sel=%b tag=%b expected sel=001 tag=1", obs[30][B_SEL +: 3], obs[30][B_TAG]);
        end
        for (int k = 0; k <= exp_done + 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec[k]) begin
                errors++;
                $display("FAIL n11_trace k=%0d got %b expected %b", k, obs[k], exp_vec[k]);
            end
        end
    endtask

    task automatic test_multi_pt();
        fill_pattern(1'b0, 1'b0);
        run_op(0);
        checks++;
        if (m_done !== 43) begin errors++; $display("FAIL n13_latency got %0d expected 43", m_done); end
        checks++;
        if (m_xfers !== 4) begin errors++; $display("FAIL n13_xfers got %0d expected 4", m_xfers); end
        checks++;
        if (m_cv !== 3) begin errors++; $display("FAIL n13_cipher_valid got %0d expected 3", m_cv); end
        checks++;
        if (m_sel100 !== 1 || m_sel100_k !== 30) begin
            errors++;
            $display("FAIL n13_sel100 got count=%0d k=%0d expected count=1 k=30", m_sel100, m_sel100_k);
        end
        for (int k = 0; k <= exp_done + 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec[k]) begin
                errors++;
                $display("FAIL n13_trace k=%0d got %b expected %b", k, obs[k], exp_vec[k]);
            end
        end
    endtask

    task automatic test_stall();
        fill_pattern(1'b0, 1'b0);
        for (int k = 19; k <= 23; k++) vpat[k] = 1'b0;
        run_op(0);
        checks++;
        if (m_done !== 48) begin errors++; $display("FAIL stall_latency got %0d expected 48", m_done); end
        for (int k = 19; k <= 23; k++) begin
            checks++;
            if ((obs[k] & 16'hFFFD) !== 16'h0000) begin
                errors++;
                $display("FAIL stall_quiet k=%0d got %b expected only busy", k, obs[k]);
            end
        end
        for (int k = 0; k <= exp_done + 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec[k]) begin
                errors++;
                $display("FAIL stall_trace k=%0d got %b expected %b", k, obs[k], exp_vec[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_pattern(1'b0, 1'b0);
        for (int k = 2; k < 60; k++) spat[k] = 1'b1;
        run_op(0);
        checks++;
        if (m_done !== 43) begin errors++; $display("FAIL busy_start_latency got %0d expected 43", m_done); end
        for (int k = 0; k <= exp_done + 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec[k]) begin
                errors++;
                $display("FAIL busy_start_trace k=%0d got %b expected %b", k, obs[k], exp_vec[k]);
            end
        end
        fill_pattern(1'b0, 1'b0);
        run_op(0);
        checks++;
        if (obs[1][B_ISEL] !== 1'b0 || obs[1][B_BUSY] !== 1'b1) begin
            errors++;
            $display("FAIL restart_round0 got isel=%b busy=%b expected isel=0 busy=1", obs[1][B_ISEL], obs[1][B_BUSY]);
        end
        checks++;
        if (m_done !== 43) begin errors++; $display("FAIL restart_latency got %0d expected 43", m_done); end
    endtask

    task automatic test_random();
        int d;
        for (int it = 0; it < 12; it++) begin
            d = $urandom_range(0, NI - 1);
            fill_pattern(1'b1, 1'b1);
            run_op(d);
            checks++;
            if (m_xfers !== nad_of(d) + npt_of(d)) begin
                errors++;
                $display("FAIL rand_xfers it=%0d got %0d expected %0d", it, m_xfers, nad_of(d) + npt_of(d));
            end
            checks++;
            if (m_done !== exp_done) begin
                errors++;
                $display("FAIL rand_latency it=%0d got %0d expected %0d", it, m_done, exp_done);
            end
            for (int k = 0; k <= exp_done + 2; k++) begin
                checks++;
                if (obs[k] !== exp_vec[k]) begin
                    errors++;
                    $display("FAIL rand_trace it=%0d inst=%0d k=%0d got %b expected %b", it, d, k, obs[k], exp_vec[k]);
                end
            end
        end
    endtask

`ifdef ASCON_CTRL_ABORT_EN
    task automatic test_abort();
        bit saw;
        start_a[1] = 1'b1;
        valid_a[1] = 1'b1;
        @(posedge clk); #1;
        start_a[1] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        abort_a[1] = 1'b1;
        @(posedge clk); #1;
        abort_a[1] = 1'b0;
        valid_a[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (outv[1] !== IDLE_VEC) begin
            errors++;
            $display("FAIL abort_idle got %b expected %b", outv[1], IDLE_VEC);
        end
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (outv[1][B_DONE] || outv[1][B_BUSY]) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_done got activity=%b expected 0", saw); end
        @(posedge clk); #1;
        $display("op abort during AD_PERM on inst=1 done");
        fill_pattern(1'b0, 1'b0);
        run_op(1);
        checks++;
        if (m_done !== 31) begin errors++; $display("FAIL abort_rerun_latency got %0d expected 31", m_done); end
    endtask
`endif

    initial begin
        resetb  = 1'b0;
        start_a = '0;
        valid_a = '0;
`ifdef ASCON_CTRL_ABORT_EN
        abort_a = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        resetb = 1'b1;
        test_reset();
        test_single_pt();
        test_multi_pt();
        test_stall();
        test_back_to_back();
        test_random();
`ifdef ASCON_CTRL_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
Control FSM that sequences the Ascon-128 permutation/XOR datapath through one full authenticated encryption: init p12, N_AD associated-data p6 rounds, N_PT plaintext blocks, finalization p12 and tag capture. It drives every datapath enable, consumes the datapath round counter value, and runs a valid/ready handshake with the 64-bit block source. It sits between the top-level sequencer and the datapath.

Parameters:
N_AD, 1, number of 64-bit associated-data blocks (>=1)
N_PT, 3, number of 64-bit plaintext blocks (>=1)

Ports:
clock_i  in  1  clock
resetb_i  in  1  synchronous active-low reset
start_i  in  1  start one encryption; sampled only in IDLE
round_i  in  4  current round from datapath counter
data_valid_i  in  1  source presents AD/PT block on datapath data_xor_up_i
data_ready_o  out  1  block consumed this cycle (transfer = valid & ready)
input_select_o  out  1  0 = load external state, 1 = feed back register
ena_cpt_o  out  1  round counter increment
init_a_o  out  1  counter preset to 0
init_b_o  out  1  counter preset to 6
ena_xor_up_o  out  1  XOR block into x0 at round entry
ena_xor_down_o  out  1  XOR pattern after last round
xor_down_sel_o  out  3  pattern bits: [0] K into x3x4, [1] domain-sep 1 into x4 LSB, [2] K into x1x2
ena_reg_state_o  out  1  state register load
ena_cipher_o  out  1  cipher register load
ena_tag_o  out  1  tag register load
cipher_valid_o  out  1  cipher register updated last cycle
busy_o  out  1  high outside IDLE
done_o  out  1  one-cycle pulse, tag register valid

Behaviour:
- Outputs decoded combinationally from state, round_i, data_valid_i; cipher_valid_o is a flop.
- Reset (resetb_i low at clock edge): state IDLE, ad_cnt = pt_cnt = 0, cipher_valid_o = 0. In IDLE all outputs 0 except init_a_o = 1. Reset mid-operation aborts; no done_o.
- IDLE: init_a_o = 1. start_i -> INIT. start_i outside IDLE is ignored.
- INIT (rounds 0..11): ena_reg_state_o = ena_cpt_o = 1. input_select_o = 0 at round 0, else 1. At round 11: ena_cpt_o = 0, init_b_o = 1, ena_xor_down_o = 1, sel = 001 -> AD_FIRST.
- AD_FIRST (round 6): stall while data_valid_i = 0 (all enables 0). With data_valid_i = 1: data_ready_o, ena_xor_up_o, ena_reg_state_o, ena_cpt_o, input_select_o = 1 -> AD_PERM.
- AD_PERM (rounds 7..11): ena_reg_state_o, ena_cpt_o. At round 11: ena_cpt_o = 0.
  - ad_cnt < N_AD-1: ad_cnt++, init_b_o -> AD_FIRST.
  - Last AD block: ena_xor_down_o, sel = 010 | (N_PT == 1 ? 100 : 000), ad_cnt = 0.
    - N_PT > 1: init_b_o -> PT_FIRST.
    - N_PT == 1: init_a_o -> FIN_FIRST.
- PT_FIRST (round 6): like AD_FIRST, plus ena_cipher_o on transfer -> PT_PERM.
- PT_PERM (rounds 7..11): at round 11, pt_cnt++.
  - New pt_cnt == N_PT-1: ena_xor_down_o, sel = 100, init_a_o -> FIN_FIRST.
  - Else: init_b_o -> PT_FIRST.
  - Key into x1x2 commutes with the x0 XOR of the final block.
- FIN_FIRST (round 0): like PT_FIRST (last PT block, ena_cipher_o) -> FIN_PERM.
- FIN_PERM (rounds 1..11): at round 11: ena_xor_down_o, sel = 001, ena_tag_o, ena_cpt_o = 0 -> DONE.
- DONE: done_o = 1 for one cycle; pt_cnt = 0 -> IDLE.
- Timing:
  - cipher_valid_o is high the cycle after each ena_cipher_o.
  - sel is 000 whenever ena_xor_down_o = 0.
  - Stall-free latency from the start_i cycle T to done_o is 19 + 6*(N_AD+N_PT) cycles.
- Exactly N_AD+N_PT transfers per operation.

Optional Feature:
ASCON_CTRL_ABORT_EN: adds input abort_i (1 bit). When defined, abort_i high at a clock edge in any non-IDLE state forces IDLE and zeroes the counters. No done_o; cipher_valid_o is cleared. abort_i has lower priority than reset. When not defined, the port is absent and the FSM always runs to DONE.

Test Plan:
- Reset mid-INIT (round 5): resetb_i low 1 cycle -> busy_o = 0, init_a_o = 1, all other outputs 0, done_o never pulses.
- N_AD=1, N_PT=1, data_valid_i always 1, start_i at T:
  - done_o at T+31; 2 transfers.
  - AD round-11 sel = 110; FIN round-11 sel = 001 with ena_tag_o.
- N_AD=1, N_PT=3, valid always 1:
  - done_o at T+43; 4 transfers; 3 cipher_valid_o pulses.
  - sel = 100 only at the end of the 2nd PT block.
- Stall: data_valid_i low for 5 cycles at PT_FIRST -> all enables 0 during stall, data_ready_o = 0, done_o delayed by exactly 5 cycles.
- start_i pulsed while busy_o = 1 -> ignored; after done_o, start_i -> new run from INIT with input_select_o = 0 at round 0.
- ASCON_CTRL_ABORT_EN: abort_i during AD_PERM -> IDLE next cycle, no done_o; the next start completes normally in T+31 (1,1).
